// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, applies writeback bypass and x0 forcing,
// and hands operands to execute through a 2-entry skid buffer that snoops writebacks.
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int SCW  = 16
) (
    input  logic            clk,
    input  logic            r,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    output logic [AW-1:0]   rf_rs1,
    output logic [AW-1:0]   rf_rs2,
    input  logic [XLEN-1:0] rf_dataA,
    input  logic [XLEN-1:0] rf_dataB,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_opA,
    output logic [XLEN-1:0] out_opB,
    output logic [AW-1:0]   out_rs1,
    output logic [AW-1:0]   out_rs2,
    output logic [SCW-1:0]  stall_cnt
);

    logic            skid_valid;
    logic [XLEN-1:0] skid_opA;
    logic [XLEN-1:0] skid_opB;
    logic [AW-1:0]   skid_rs1;
    logic [AW-1:0]   skid_rs2;

    logic            accept;
    logic            out_free;
    logic            pop;
    logic            wb_live;
    logic [XLEN-1:0] cap_opA;
    logic [XLEN-1:0] cap_opB;
    logic [XLEN-1:0] snp_out_opA;
    logic [XLEN-1:0] snp_out_opB;
    logic [XLEN-1:0] snp_skid_opA;
    logic [XLEN-1:0] snp_skid_opB;

    assign rf_rs1   = in_rs1;
    assign rf_rs2   = in_rs2;
    assign in_ready = !r && !skid_valid;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;
    assign pop      = out_valid && out_ready;
    assign wb_live  = wb_valid && (wb_rd != '0);

    // Capture path: x0 reads as zero, and a same-cycle writeback wins over the stale rf read.
    always_comb begin
        cap_opA = rf_dataA;
        cap_opB = rf_dataB;
        if (in_rs1 == '0)
            cap_opA = '0;
        else if (wb_live && wb_rd == in_rs1)
            cap_opA = wb_data;
        if (in_rs2 == '0)
            cap_opB = '0;
        else if (wb_live && wb_rd == in_rs2)
            cap_opB = wb_data;
    end

    always_comb begin
        snp_out_opA  = (wb_live && wb_rd == out_rs1)  ? wb_data : out_opA;
        snp_out_opB  = (wb_live && wb_rd == out_rs2)  ? wb_data : out_opB;
        snp_skid_opA = (wb_live && wb_rd == skid_rs1) ? wb_data : skid_opA;
        snp_skid_opB = (wb_live && wb_rd == skid_rs2) ? wb_data : skid_opB;
    end

    always_ff @(posedge clk) begin
        if (r) begin
            out_valid  <= 1'b0;
            out_opA    <= '0;
            out_opB    <= '0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            skid_valid <= 1'b0;
            skid_opA   <= '0;
            skid_opB   <= '0;
            skid_rs1   <= '0;
            skid_rs2   <= '0;
        end else if (accept && out_free) begin
            out_valid <= 1'b1;
            out_opA   <= cap_opA;
            out_opB   <= cap_opB;
            out_rs1   <= in_rs1;
            out_rs2   <= in_rs2;
        end else if (accept) begin
            // Output is stalled here, so the held entry keeps snooping while the skid fills.
            skid_valid <= 1'b1;
            skid_opA   <= cap_opA;
            skid_opB   <= cap_opB;
            skid_rs1   <= in_rs1;
            skid_rs2   <= in_rs2;
            out_opA    <= snp_out_opA;
            out_opB    <= snp_out_opB;
        end else if (pop && skid_valid) begin
            skid_valid <= 1'b0;
            out_opA    <= snp_skid_opA;
            out_opB    <= snp_skid_opB;
            out_rs1    <= skid_rs1;
            out_rs2    <= skid_rs2;
        end else if (pop) begin
            out_valid <= 1'b0;
        end else begin
            if (out_valid) begin
                out_opA <= snp_out_opA;
                out_opB <= snp_out_opB;
            end
            if (skid_valid) begin
                skid_opA <= snp_skid_opA;
                skid_opB <= snp_skid_opB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != {SCW{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: fetch, x0/bypass, skid backpressure, snooping,
// mid-operation reset and stall counter saturation.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        r;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [31:0] rf_dataA;
    logic [31:0] rf_dataB;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_opA;
    logic [31:0] out_opB;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [3:0]  stall_cnt;

    logic [31:0] rf [32];
    int numChecks = 0;
    int numFails  = 0;

    always #5 clk = ~clk;

    assign rf_dataA = rf[rf_rs1];
    assign rf_dataB = rf[rf_rs2];

    operand_fetch #(.XLEN(32), .AW(5), .SCW(4)) dut (
        .clk       (clk),
        .r         (r),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .rf_rs1    (rf_rs1),
        .rf_rs2    (rf_rs2),
        .rf_dataA  (rf_dataA),
        .rf_dataB  (rf_dataB),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_opA   (out_opA),
        .out_opB   (out_opB),
        .out_rs1   (out_rs1),
        .out_rs2   (out_rs2),
        .stall_cnt (stall_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [4:0] b);
        in_valid = v;
        in_rs1   = a;
        in_rs2   = b;
    endtask

    task automatic applyWb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    task automatic applyReset();
        r = 1'b1;
        applyStimulus(1'b0, 5'd0, 5'd0);
        step();
        r = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
        rf[0] = 32'hFFFF_FFFF;
        rf[1] = 32'h1;  rf[2] = 32'h2;  rf[3] = 32'h3;  rf[4] = 32'h4;
        rf[5] = 32'h11; rf[6] = 32'h22; rf[7] = 32'h777; rf[9] = 32'h9;
        r = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 5'd0, 5'd0);
        applyWb(1'b0, 5'd0, 32'd0);

        // Reset state
        step();
        step();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_stall", 32'(stall_cnt), 32'd0);
        checkOutput("rst_opA", out_opA, 32'd0);
        r = 1'b0;
        step();
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Single fetch
        applyStimulus(1'b1, 5'd5, 5'd6);
        #1;
        checkOutput("rf_rs1_comb", 32'(rf_rs1), 32'd5);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0);
        checkOutput("f1_valid", 32'(out_valid), 32'd1);
        checkOutput("f1_opA", out_opA, 32'h11);
        checkOutput("f1_opB", out_opB, 32'h22);
        checkOutput("f1_rs2", 32'(out_rs2), 32'd6);
        step();
        checkOutput("f1_drain", 32'(out_valid), 32'd0);

        // x0 forcing and writeback bypass
        applyStimulus(1'b1, 5'd0, 5'd7);
        applyWb(1'b1, 5'd7, 32'hABCD);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0);
        applyWb(1'b0, 5'd0, 32'd0);
        checkOutput("byp_opA_x0", out_opA, 32'd0);
        checkOutput("byp_opB", out_opB, 32'hABCD);
        step();

        // Backpressure into the skid buffer
        out_ready = 1'b0;
        applyStimulus(1'b1, 5'd1, 5'd1);
        step();
        applyStimulus(1'b1, 5'd2, 5'd2);
        checkOutput("bp_in_ready_1", 32'(in_ready), 32'd1);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0);
        checkOutput("bp_in_ready_0", 32'(in_ready), 32'd0);
        step();
        step();
        checkOutput("bp_stall3", 32'(stall_cnt), 32'd3);
        checkOutput("bp_head_opA", out_opA, 32'h1);
        out_ready = 1'b1;
        step();
        checkOutput("bp_second_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_second_opA", out_opA, 32'h2);
        checkOutput("bp_in_ready_back", 32'(in_ready), 32'd1);
        checkOutput("bp_stall_hold", 32'(stall_cnt), 32'd3);
        step();
        checkOutput("bp_drain", 32'(out_valid), 32'd0);

        // Snooping of held out and skid entries
        applyReset();
        out_ready = 1'b0;
        applyStimulus(1'b1, 5'd9, 5'd3);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0);
        applyWb(1'b1, 5'd9, 32'h99);
        step();
        applyWb(1'b1, 5'd0, 32'hDEAD);
        checkOutput("snp_opA", out_opA, 32'h99);
        checkOutput("snp_opB_kept", out_opB, 32'h3);
        step();
        applyWb(1'b0, 5'd0, 32'd0);
        checkOutput("snp_x0_opA", out_opA, 32'h99);
        checkOutput("snp_x0_opB", out_opB, 32'h3);
        applyStimulus(1'b1, 5'd9, 5'd4);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0);
        applyWb(1'b1, 5'd9, 32'h55);
        step();
        applyWb(1'b0, 5'd0, 32'd0);
        checkOutput("snp2_out_opA", out_opA, 32'h55);
        out_ready = 1'b1;
        step();
        checkOutput("snp_skid_opA", out_opA, 32'h55);
        checkOutput("snp_skid_opB", out_opB, 32'h4);
        checkOutput("snp_skid_rs2", 32'(out_rs2), 32'd4);
        step();

        // Reset with both entries full
        out_ready = 1'b0;
        applyStimulus(1'b1, 5'd1, 5'd2);
        step();
        step();
        applyStimulus(1'b0, 5'd0, 5'd0);
        checkOutput("mid_full", 32'(in_ready), 32'd0);
        r = 1'b1;
        step();
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("mid_rst_stall", 32'(stall_cnt), 32'd0);
        r = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("mid_after_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_after_valid", 32'(out_valid), 32'd0);

        // Stall counter saturation
        out_ready = 1'b0;
        applyStimulus(1'b1, 5'd5, 5'd6);
        step();
        applyStimulus(1'b0, 5'd0, 5'd0);
        for (int i = 0; i < 14; i++) step();
        checkOutput("sat_14", 32'(stall_cnt), 32'd14);
        for (int i = 0; i < 6; i++) step();
        checkOutput("sat_15", 32'(stall_cnt), 32'd15);
        checkOutput("sat_held_opA", out_opA, 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
